// File: rtl/i_reg_wb_scheduler_pkg.sv
// Shared types for the integer register file writeback path: register names,
// data bus, writeback request record and the busy scoreboard.
package i_reg_wb_scheduler_pkg;

  typedef enum logic [4:0] {
    X0,  X1,  X2,  X3,  X4,  X5,  X6,  X7,
    X8,  X9,  X10, X11, X12, X13, X14, X15,
    X16, X17, X18, X19, X20, X21, X22, X23,
    X24, X25, X26, X27, X28, X29, X30, X31
  } i_register_e;

  typedef logic [31:0] data_bus_t;

  localparam int N_WB_REQ = 4;

  typedef struct packed {
    logic        valid;
    i_register_e addr;
    data_bus_t   data;
  } wb_req_t;

  typedef logic [31:0] scoreboard_t;

endpackage

// File: rtl/wb_prio_arbiter.sv
// Fixed-priority arbiter with per-requester aging counters; a requester that
// has lost STARVE_LIMIT cycles in a row outranks the base priority order.
module wb_prio_arbiter #(
  parameter int N_REQ        = 4,
  parameter int STARVE_LIMIT = 7,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] valid,
  output logic [N_REQ-1:0] grant
);

  logic [CNT_W-1:0] age [N_REQ];
  logic [N_REQ-1:0] starved;
  logic [N_REQ-1:0] pick;

  always_comb begin
    starved = '0;
    for (int i = 0; i < N_REQ; i++) begin
      starved[i] = valid[i] && (age[i] == CNT_W'(STARVE_LIMIT));
    end
  end

  // Isolating the lowest set bit of the candidate set gives the fixed-priority winner.
  assign pick  = (|starved) ? starved : valid;
  assign grant = rst_n ? (pick & (~pick + N_REQ'(1))) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (valid[i] && !grant[i]) begin
          if (age[i] != CNT_W'(STARVE_LIMIT)) begin
            age[i] <= age[i] + CNT_W'(1);
          end
        end else begin
          age[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/i_reg_wb_scheduler.sv
// Integer register file writeback scheduler: arbitrates the single write port
// among the writeback units and tracks pending destinations for decode stalls.
module i_reg_wb_scheduler
  import i_reg_wb_scheduler_pkg::*;
#(
  parameter int N_REQ        = N_WB_REQ,
  parameter int STARVE_LIMIT = 7,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        issue_valid_i,
  input  i_register_e issue_rd_i,
  input  i_register_e issue_rs1_i,
  input  i_register_e issue_rs2_i,
  output logic        issue_stall_o,
  input  logic [N_REQ-1:0] wb_valid_i,
  input  i_register_e wb_addr_i [N_REQ],
  input  data_bus_t   wb_data_i [N_REQ],
  output logic [N_REQ-1:0] wb_ready_o,
  output logic        rf_we_o,
  output i_register_e rf_waddr_o,
  output data_bus_t   rf_wdata_o,
  output scoreboard_t busy_o
);

  wb_req_t     reqs [N_REQ];
  logic [N_REQ-1:0] grant;
  logic        sel_valid;
  i_register_e sel_addr;
  data_bus_t   sel_data;
  scoreboard_t busy;
  scoreboard_t busy_next;
  logic        issue_accept;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      reqs[i] = '{valid: wb_valid_i[i], addr: wb_addr_i[i], data: wb_data_i[i]};
    end
  end

  wb_prio_arbiter #(
    .N_REQ        (N_REQ),
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_arbiter (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .valid (wb_valid_i),
    .grant (grant)
  );

  assign wb_ready_o = grant;

  always_comb begin
    sel_valid = 1'b0;
    sel_addr  = X0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i] && reqs[i].valid) begin
        sel_valid = 1'b1;
        sel_addr  = reqs[i].addr;
        sel_data  = reqs[i].data;
      end
    end
  end

  assign issue_stall_o = issue_valid_i &
                         (busy[issue_rs1_i] | busy[issue_rs2_i] | busy[issue_rd_i]);
  assign issue_accept  = issue_valid_i & ~issue_stall_o;

  // Clear tracks the register file write itself, so readers stall through the write cycle; set wins on collision.
  always_comb begin
    busy_next = busy;
    if (rf_we_o) begin
      busy_next[rf_waddr_o] = 1'b0;
    end
    if (issue_accept && (issue_rd_i != X0)) begin
      busy_next[issue_rd_i] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= X0;
      rf_wdata_o <= '0;
      busy       <= '0;
    end else begin
      rf_we_o <= sel_valid && (sel_addr != X0);
      if (sel_valid) begin
        rf_waddr_o <= sel_addr;
        rf_wdata_o <= sel_data;
      end
      busy <= busy_next;
    end
  end

  assign busy_o = busy;

endmodule

// File: doc/i_reg_wb_scheduler.md
Name: i_reg_wb_scheduler

Overview:
- Shares the single write port of the integer register file between N_REQ writeback requesters: ALU, MUL, DIV and LSU.
- Keeps a 32-entry busy scoreboard so decode can stall on RAW/WAW hazards.
- Arbitration is fixed-priority with anti-starvation aging.
- Write-port outputs are registered and drive the register file's write enable, write address and write data directly.

Parameters:
- N_REQ, 4, number of writeback requesters; index 0 has the highest base priority.
- STARVE_LIMIT, 7, consecutive lost-arbitration cycles after which a requester is promoted.
- CNT_W, $clog2(STARVE_LIMIT+1), aging counter width (derived).

Ports:
- clk_i  in  1  clock, all state on posedge
- rst_n_i  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decode wants to issue an instruction
- issue_rd_i  in  i_register_e  destination of issuing instruction
- issue_rs1_i  in  i_register_e  source 1 of issuing instruction
- issue_rs2_i  in  i_register_e  source 2 of issuing instruction
- issue_stall_o  out  1  hazard; the issue is not accepted this cycle
- wb_valid_i  in  N_REQ  per-requester writeback request
- wb_addr_i  in  N_REQ x i_register_e  per-requester destination
- wb_data_i  in  N_REQ x data_bus_t  per-requester result
- wb_ready_o  out  N_REQ  one-hot grant; transfer when valid & ready
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  i_register_e  register file write address
- rf_wdata_o  out  data_bus_t  register file write data
- busy_o  out  32  scoreboard vector, for debug/forwarding

Behaviour:
- Reset (async assert, sync release): busy all 0, aging counters 0, rf_we_o=0, rf_waddr_o=X0, rf_wdata_o=0.
- Combinational outputs during reset: wb_ready_o=0; issue_stall_o follows busy, which reads 0.
- Reset mid-transfer drops any pending write.

Arbitration (combinational, one grant per cycle):
- Starved set = requesters with wb_valid_i=1 and counter==STARVE_LIMIT.
- If the starved set is non-empty, grant its lowest index; otherwise grant the lowest-index valid requester.
- wb_ready_o[i]=1 only for the granted i. It never asserts without the matching wb_valid_i.
- A requester holds valid/addr/data stable until it sees ready. Valid must not drop without ready (bench asserts this).

Aging counters (per requester, each cycle):
- valid & !ready: increment, saturating at STARVE_LIMIT.
- Granted or !valid: clear to 0.

Write port:
- A grant in cycle N gives rf_we_o=1 in cycle N+1, with the granted addr/data registered. The register file writes at the end of N+1.
- Grant to X0: handshake completes, rf_we_o stays 0.
- Cycles with no grant: rf_we_o=0; addr/data hold their last values.
- Throughput: 1 write per cycle.

Scoreboard:
- Issue is accepted when issue_valid_i & !issue_stall_o.
- issue_stall_o = issue_valid_i & (busy[rs1] | busy[rs2] | busy[rd]). busy[X0] is hardwired 0.
- An accepted issue with rd != X0 sets busy[rd] at the next edge.
- busy[a] clears at the same edge the register file writes a (end of cycle N+1), so a reader in N+1 still stalls. No bypass.
- Simultaneous set and clear of the same index: set wins. Only reachable after a protocol violation, since WAW stalls.
- The scoreboard does not check wb_addr_i against busy. Writebacks to non-busy registers are written anyway.

Decomposition:
- Add to the shared modules package: N_WB_REQ=4, the wb_req_t struct {valid, i_register_e addr, data_bus_t data}, and scoreboard_t (logic [31:0]).
- Reuse i_register_e and data_bus_t unchanged.
- One sub-module: wb_prio_arbiter. It contains the combinational aging-aware fixed-priority grant and the counters, parameterised on N_REQ and STARVE_LIMIT.
- The top module holds the scoreboard and the output register.

Test Plan:
- Reset mid-write: assert rst_n_i=0 while rf_we_o=1 -> rf_we_o=0 and busy_o=0 immediately; no write occurs after release.
- Single writeback: issue rd=x5, then wb_valid_i[2]=1 with addr=x5, data=32'hDEADBEEF -> wb_ready_o=4'b0100 same cycle. Next cycle rf_we_o=1, rf_waddr_o=x5, rf_wdata_o=32'hDEADBEEF. busy_o[5] clears at the end of that cycle.
- RAW stall: busy x7, issue rs1=x7 -> issue_stall_o=1 through the rf_we_o cycle; it drops in the following cycle.
- Priority plus starvation: requesters 0 and 3 valid continuously, requester 0 re-requesting every cycle -> req 0 wins 7 cycles, req 3 is granted in the 8th cycle, then req 0 again.
- X0 write: wb_addr_i[1]=X0 -> wb_ready_o[1]=1, rf_we_o stays 0. Issue with rd=X0 never sets busy and never stalls.
- Back-to-back: all four requesters valid for 4 cycles -> grant order 0,1,2,3; rf_we_o=1 for 4 consecutive cycles with matching addr/data.
